// File: rtl/pipe_pkg.sv
// ============================================================================
// pipe_pkg : shared control-bundle layout and defaults for pipeline stage regs
// Revision : 1.0
// ============================================================================
`default_nettype none

package pipe_pkg;

   localparam int PERF_W = 32;

   // Control bundle layout (LSB first); load flag sits in bit 0 so a single
   // pass-mask bit lets it clear while the stage is held.
   localparam int CTRL_W_DEF      = 8;
   localparam int CTRL_LOAD_BIT   = 0;
   localparam int CTRL_RFWE_BIT   = 1;
   localparam int CTRL_DMWE_BIT   = 2;
   localparam int CTRL_WDSEL_LSB  = 3;
   localparam int CTRL_WDSEL_W    = 2;
   localparam int CTRL_ALUOP_LSB  = 5;
   localparam int CTRL_ALUOP_W    = 3;

   localparam logic [CTRL_W_DEF-1:0] DEF_BUBBLE_CTRL = 8'h00;

   typedef struct packed {
      logic [CTRL_ALUOP_W-1:0] alu_op;
      logic [CTRL_WDSEL_W-1:0] wd_sel;
      logic                    dm_we;
      logic                    rf_we;
      logic                    load;
   } ctrl_t;

endpackage

`default_nettype wire

// File: rtl/pipe_stage_reg_sat_counter.sv
// ============================================================================
// sat_counter : W-bit up counter with synchronous clear, saturates at all-ones
// Revision    : 1.0
// ============================================================================
`default_nettype none

module sat_counter #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] cnt
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (inc && (cnt != {W{1'b1}})) begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

`default_nettype wire

// File: rtl/pipe_stage_reg.sv
// ============================================================================
// pipe_stage_reg : pipeline stage latch with stall, flush, ctrl pass-through
//                  and stall-run tracking. Perf counters: PIPE_STAGE_PERF_EN.
// Revision       : 1.0
// ============================================================================
`default_nettype none

module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int                  DATA_W      = 128,
   parameter int                  CTRL_W      = 8,
   parameter logic [CTRL_W-1:0]   BUBBLE_CTRL = CTRL_W'(DEF_BUBBLE_CTRL),
   parameter logic [CTRL_W-1:0]   PASS_MASK   = '0,
   parameter int                  RUN_W       = 4,
   parameter int                  MAX_STALL   = 15
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              stall_i,
   input  logic              flush_i,
   input  logic              in_valid_i,
   input  logic [CTRL_W-1:0] in_ctrl_i,
   input  logic [DATA_W-1:0] in_data_i,
   output logic              out_valid_o,
   output logic [CTRL_W-1:0] out_ctrl_o,
   output logic [DATA_W-1:0] out_data_o,
   output logic              stalled_o,
   output logic [RUN_W-1:0]  stall_run_o,
   output logic              stall_timeout_o,
   output logic [PERF_W-1:0] perf_stall_o,
   output logic [PERF_W-1:0] perf_flush_o
);

   logic             hold;
   logic [RUN_W-1:0] next_run;
   logic             timeout_d;

   // flush overrides stall, so a flushed cycle never counts as a hold
   assign hold     = stall_i && !flush_i;
   assign next_run = !hold                       ? '0 :
                     (stall_run_o == {RUN_W{1'b1}}) ? stall_run_o :
                                                     stall_run_o + 1'b1;
   assign timeout_d = (next_run == RUN_W'(MAX_STALL)) ||
                      (hold && (stall_run_o >= RUN_W'(MAX_STALL)));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_o     <= 1'b0;
         out_ctrl_o      <= BUBBLE_CTRL;
         out_data_o      <= '0;
         stalled_o       <= 1'b0;
         stall_timeout_o <= 1'b0;
      end else if (flush_i) begin
         out_valid_o     <= 1'b0;
         out_ctrl_o      <= BUBBLE_CTRL;
         stalled_o       <= 1'b0;
         stall_timeout_o <= 1'b0;
      end else if (stall_i) begin
         out_ctrl_o      <= (PASS_MASK & in_ctrl_i) | (~PASS_MASK & out_ctrl_o);
         stalled_o       <= 1'b1;
         stall_timeout_o <= timeout_d;
      end else begin
         out_valid_o     <= in_valid_i;
         out_ctrl_o      <= in_ctrl_i;
         out_data_o      <= in_data_i;
         stalled_o       <= 1'b0;
         stall_timeout_o <= 1'b0;
      end
   end

   sat_counter #(.W(RUN_W)) u_stall_run (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (hold),
      .clr   (!hold),
      .cnt   (stall_run_o)
   );

`ifdef PIPE_STAGE_PERF_EN
   generate
      if (1) begin : g_perf
         sat_counter #(.W(PERF_W)) u_perf_stall (
            .clk   (clk),
            .rst_n (rst_n),
            .inc   (hold),
            .clr   (1'b0),
            .cnt   (perf_stall_o)
         );
         sat_counter #(.W(PERF_W)) u_perf_flush (
            .clk   (clk),
            .rst_n (rst_n),
            .inc   (flush_i),
            .clr   (1'b0),
            .cnt   (perf_flush_o)
         );
      end
   endgenerate
`else
   assign perf_stall_o = '0;
   assign perf_flush_o = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
// ============================================================================
// tb_pipe_stage_reg : directed self-checking bench for pipe_stage_reg
// Revision          : 1.0
// ============================================================================
`default_nettype none

module tb_pipe_stage_reg;

   localparam int DW = 128;
   localparam int CW = 8;
   localparam logic [CW-1:0] BUB = 8'h5A;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          stall_i, flush_i, in_valid_i;
   logic [CW-1:0] in_ctrl_i;
   logic [DW-1:0] in_data_i;
   logic          out_valid_o;
   logic [CW-1:0] out_ctrl_o;
   logic [DW-1:0] out_data_o;
   logic          stalled_o;
   logic [3:0]    stall_run_o;
   logic          stall_timeout_o;
   logic [31:0]   perf_stall_o, perf_flush_o;

   int tests = 0;
   int fails = 0;
   int exp_pstall = 0;
   int exp_pflush = 0;

   pipe_stage_reg #(
      .DATA_W(DW), .CTRL_W(CW), .BUBBLE_CTRL(BUB), .PASS_MASK(8'h01),
      .RUN_W(4), .MAX_STALL(15)
   ) dut (
      .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .flush_i(flush_i),
      .in_valid_i(in_valid_i), .in_ctrl_i(in_ctrl_i), .in_data_i(in_data_i),
      .out_valid_o(out_valid_o), .out_ctrl_o(out_ctrl_o), .out_data_o(out_data_o),
      .stalled_o(stalled_o), .stall_run_o(stall_run_o),
      .stall_timeout_o(stall_timeout_o),
      .perf_stall_o(perf_stall_o), .perf_flush_o(perf_flush_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_perf(input string tag);
`ifdef PIPE_STAGE_PERF_EN
      check({tag, "_pstall"}, DW'(perf_stall_o), DW'(exp_pstall));
      check({tag, "_pflush"}, DW'(perf_flush_o), DW'(exp_pflush));
`else
      check({tag, "_pstall"}, DW'(perf_stall_o), '0);
      check({tag, "_pflush"}, DW'(perf_flush_o), '0);
`endif
   endtask

   task automatic check_out(input string tag, input logic v, input logic [CW-1:0] c,
                            input logic [DW-1:0] d, input logic st, input logic [3:0] run,
                            input logic to);
      check({tag, "_valid"},   DW'(out_valid_o),     DW'(v));
      check({tag, "_ctrl"},    DW'(out_ctrl_o),      DW'(c));
      check({tag, "_data"},    out_data_o,           d);
      check({tag, "_stalled"}, DW'(stalled_o),       DW'(st));
      check({tag, "_run"},     DW'(stall_run_o),     DW'(run));
      check({tag, "_timeout"}, DW'(stall_timeout_o), DW'(to));
   endtask

   logic [DW-1:0] d1, d2, d3, d4, dx;

   initial begin
      d1 = {4{32'hDEADBEEF}};
      d2 = {4{32'hDEADC0DE}};
      d3 = {4{32'hDEAD1234}};
      d4 = {4{32'h0BADF00D}};
      dx = {4{32'hFFFF0000}};

      // reset with every input forced high
      rst_n = 1'b0; stall_i = 1'b1; flush_i = 1'b1; in_valid_i = 1'b1;
      in_ctrl_i = '1; in_data_i = '1;
      tick();
      check_out("reset", 1'b0, BUB, '0, 1'b0, 4'd0, 1'b0);
      check_perf("reset");

      @(negedge clk);
      rst_n = 1'b1; stall_i = 1'b0; flush_i = 1'b0;
      in_valid_i = 1'b1; in_ctrl_i = 8'h11; in_data_i = d1;
      #1;
      check("no_comb_path_data", out_data_o, '0);
      tick();
      check_out("adv1", 1'b1, 8'h11, d1, 1'b0, 4'd0, 1'b0);
      in_ctrl_i = 8'h22; in_data_i = d2;
      tick();
      check_out("adv2", 1'b1, 8'h22, d2, 1'b0, 4'd0, 1'b0);
      in_ctrl_i = 8'h33; in_data_i = d3;
      tick();
      check_out("adv3", 1'b1, 8'h33, d3, 1'b0, 4'd0, 1'b0);

      // stall: only ctrl[0] follows input
      stall_i = 1'b1; in_valid_i = 1'b0; in_data_i = dx;
      in_ctrl_i = 8'hC0;
      tick(); exp_pstall++;
      check_out("stall1", 1'b1, 8'h32, d3, 1'b1, 4'd1, 1'b0);
      in_ctrl_i = 8'hFF;
      tick(); exp_pstall++;
      check_out("stall2", 1'b1, 8'h33, d3, 1'b1, 4'd2, 1'b0);
      in_ctrl_i = 8'h0E;
      tick(); exp_pstall++;
      check_out("stall3", 1'b1, 8'h32, d3, 1'b1, 4'd3, 1'b0);

      // flush wins over stall; data held
      flush_i = 1'b1;
      tick(); exp_pflush++;
      check_out("flush", 1'b0, BUB, d3, 1'b0, 4'd0, 1'b0);
      check_perf("flush");

      // advance with a bubble still loads ctrl/data
      flush_i = 1'b0; stall_i = 1'b0; in_valid_i = 1'b0;
      in_ctrl_i = 8'h77; in_data_i = d4;
      tick();
      check_out("bubble", 1'b0, 8'h77, d4, 1'b0, 4'd0, 1'b0);

      // long stall: timeout on 15th edge, run saturates
      stall_i = 1'b1; in_ctrl_i = 8'h00;
      for (int i = 1; i <= 20; i++) begin
         tick(); exp_pstall++;
         check($sformatf("tmo_run%0d", i), DW'(stall_run_o), DW'((i > 15) ? 15 : i));
         check($sformatf("tmo_flag%0d", i), DW'(stall_timeout_o), DW'(i >= 15));
      end
      check("tmo_ctrl_low_tracks", DW'(out_ctrl_o), DW'(8'h76));
      stall_i = 1'b0; in_valid_i = 1'b1; in_ctrl_i = 8'h44; in_data_i = d1;
      tick();
      check_out("tmo_clear", 1'b1, 8'h44, d1, 1'b0, 4'd0, 1'b0);
      check_perf("pre_rst");

      // async reset between edges while stalled
      stall_i = 1'b1;
      tick(); tick(); exp_pstall += 2;
      check("prerst_run", DW'(stall_run_o), DW'(2));
      #2;
      rst_n = 1'b0;
      #1;
      exp_pstall = 0; exp_pflush = 0;
      check_out("async_rst", 1'b0, BUB, '0, 1'b0, 4'd0, 1'b0);
      check_perf("async_rst");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

`default_nettype wire
